alu_cmd_sequencer: RTL and testbench

Command front-end that sits directly upstream of the 4-bit ALU top. It accepts operand/opcode commands over a valid/ready handshake and buffers them in a small FIFO. It issues them one at a time on registered ALU input buses, samples the 8-bit ALU result after a fixed latency, and presents each result over a valid/ready response port. This decouples a bursty host or serial loader from the ALU and guarantees stable operands for the full evaluation window.

---
 rtl/alu_seq_pkg.sv | 23 ++
 rtl/alu_seq_fifo.sv | 71 +++++++
 rtl/alu_cmd_sequencer.sv | 179 +++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and widths for the ALU command sequencer.
// ALU_SEQ_CHAIN_EN adds a chain bit to each stored command entry.
package alu_seq_pkg;

    localparam int ALU_IN_W  = 4;
    localparam int ALU_OUT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } seq_state_t;

    typedef struct packed {
`ifdef ALU_SEQ_CHAIN_EN
        logic                chain;
`endif
        logic [ALU_IN_W-1:0] a;
        logic [ALU_IN_W-1:0] b;
        logic [ALU_IN_W-1:0] op;
    } cmd_entry_t;

endpackage

// File: rtl/alu_seq_fifo.sv
// Synchronous FIFO for command entries. Power-of-two depth, so the pointers
// wrap naturally; the occupancy count separates full from empty.
module alu_seq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 12,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing is read until a push has written it.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands, issues them on registered operand buses and returns
// each sampled result over valid/ready. ALU_SEQ_CHAIN_EN enables result chaining.
//
// state | meaning
// IDLE  | no command in flight; issue the FIFO head when one is present
// WAIT  | operands on the ALU, counting down the evaluation latency
// HOLD  | result captured and offered until rsp_ready
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ALU_LAT    = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [ALU_IN_W-1:0]           cmd_a,
    input  logic [ALU_IN_W-1:0]           cmd_b,
    input  logic [ALU_IN_W-1:0]           cmd_op,
    input  logic                          cmd_chain,
    output logic [ALU_IN_W-1:0]           alu_a,
    output logic [ALU_IN_W-1:0]           alu_b,
    output logic [ALU_IN_W-1:0]           alu_op,
    input  logic [ALU_OUT_W-1:0]          alu_result,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ALU_OUT_W-1:0]          rsp_data,
    output logic [ALU_IN_W-1:0]           rsp_op,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam logic [2:0] LAT_LOAD = 3'(ALU_LAT - 1);

    seq_state_t            state_q, state_d;
    logic [ALU_IN_W-1:0]   alu_a_q, alu_a_d;
    logic [ALU_IN_W-1:0]   alu_b_q, alu_b_d;
    logic [ALU_IN_W-1:0]   alu_op_q, alu_op_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [ALU_OUT_W-1:0]  rsp_data_q, rsp_data_d;
    logic [ALU_IN_W-1:0]   rsp_op_q, rsp_op_d;
    logic [2:0]            lat_cnt_q, lat_cnt_d;

    cmd_entry_t            push_entry;
    cmd_entry_t            head_entry;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  issue;
    logic [ALU_IN_W-1:0]   issue_a;

    always_comb begin
        push_entry    = '0;
        push_entry.a  = cmd_a;
        push_entry.b  = cmd_b;
        push_entry.op = cmd_op;
`ifdef ALU_SEQ_CHAIN_EN
        push_entry.chain = cmd_chain;
`endif
    end

`ifdef ALU_SEQ_CHAIN_EN
    logic [ALU_IN_W-1:0] chain_q, chain_d;
    assign issue_a = head_entry.chain ? chain_q : head_entry.a;
`else
    logic unused_cmd_chain;
    assign unused_cmd_chain = cmd_chain;
    assign issue_a          = head_entry.a;
`endif

    assign cmd_ready = !rst && !fifo_full;
    assign fifo_push = cmd_valid && cmd_ready;

    alu_seq_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(cmd_entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (push_entry),
        .pop   (fifo_pop),
        .rdata (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_op_d    = rsp_op_q;
        lat_cnt_d   = lat_cnt_q;
        issue       = 1'b0;
`ifdef ALU_SEQ_CHAIN_EN
        chain_d     = chain_q;
`endif
        case (state_q)
            IDLE: begin
                if (!fifo_empty) issue = 1'b1;
            end
            WAIT: begin
                if (lat_cnt_q == 3'd0) begin
                    rsp_data_d  = alu_result;
                    rsp_op_d    = alu_op_q;
                    rsp_valid_d = 1'b1;
                    state_d     = HOLD;
`ifdef ALU_SEQ_CHAIN_EN
                    chain_d     = alu_result[ALU_IN_W-1:0];
`endif
                end else begin
                    lat_cnt_d = lat_cnt_q - 3'd1;
                end
            end
            HOLD: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (!fifo_empty) issue = 1'b1;
                    else             state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Pop and operand load happen together so alu_* only ever carry issued data.
        if (issue) begin
            alu_a_d   = issue_a;
            alu_b_d   = head_entry.b;
            alu_op_d  = head_entry.op;
            lat_cnt_d = LAT_LOAD;
            state_d   = WAIT;
        end
    end

    assign fifo_pop = issue;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_op_q    <= '0;
            lat_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_op_q    <= rsp_op_d;
            lat_cnt_q   <= lat_cnt_d;
        end
    end

`ifdef ALU_SEQ_CHAIN_EN
    always_ff @(posedge clk) begin
        if (rst) chain_q <= '0;
        else     chain_q <= chain_d;
    end
`endif

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_op    = rsp_op_q;
    assign busy      = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with an ALU stub returning {alu_b, alu_a}.
module tb_alu_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a, cmd_b, cmd_op;
    logic       cmd_chain;
    logic [3:0] alu_a, alu_b, alu_op;
    logic [7:0] alu_result;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [3:0] rsp_op;
    logic       busy;
    logic [2:0] fifo_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign alu_result = {alu_b, alu_a};

    alu_cmd_sequencer #(.FIFO_DEPTH(4), .ALU_LAT(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_op     (cmd_op),
        .cmd_chain  (cmd_chain),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_op     (rsp_op),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_chain = 1'b0;
        step(); step();
        n_checks++;
        if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_ready got %b exp 0", cmd_ready); end
        n_checks++;
        if ({alu_a, alu_b, alu_op} !== 12'h000) begin n_fail++; $display("FAIL reset_alu got %h exp 000", {alu_a, alu_b, alu_op}); end
        n_checks++;
        if ({rsp_valid, rsp_data, rsp_op} !== 13'h0) begin n_fail++; $display("FAIL reset_rsp got v=%b d=%h op=%h exp 0", rsp_valid, rsp_data, rsp_op); end
        n_checks++;
        if ({busy, fifo_count} !== 4'h0) begin n_fail++; $display("FAIL reset_busy_count got busy=%b cnt=%0d exp 0", busy, fifo_count); end
        rst = 1'b0;
        step();
        n_checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_ready got ready=%b busy=%b exp 1/0", cmd_ready, busy); end
    endtask

    task automatic test_single();
        rsp_ready = 1'b1;
        cmd_a = 4'd3; cmd_b = 4'd5; cmd_op = 4'd2; cmd_chain = 1'b0; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        n_checks++;
        if (fifo_count !== 3'd1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_e0 got cnt=%0d v=%b exp 1/0", fifo_count, rsp_valid); end
        step();
        n_checks++;
        if ({alu_a, alu_b, alu_op} !== 12'h352 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_e1 got alu=%h v=%b exp 352/0", {alu_a, alu_b, alu_op}, rsp_valid); end
        step();
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 8'h53 || rsp_op !== 4'd2) begin n_fail++; $display("FAIL single_rsp got v=%b d=%h op=%h exp 1/53/2", rsp_valid, rsp_data, rsp_op); end
        step();
        n_checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL single_done got v=%b busy=%b exp 0/0", rsp_valid, busy); end
    endtask

    task automatic test_fill_backpressure();
        int exp_cnt [5] = '{1, 1, 2, 3, 4};
        int bad = 0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cmd_a = 4'(i + 1); cmd_b = 4'(i + 8); cmd_op = 4'(i + 4); cmd_valid = 1'b1;
            step();
            n_checks++;
            if (fifo_count !== 3'(exp_cnt[i])) begin n_fail++; $display("FAIL fill_count_%0d got %0d exp %0d", i, fifo_count, exp_cnt[i]); end
        end
        cmd_valid = 1'b0;
        n_checks++;
        if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full_ready got %b exp 0", cmd_ready); end
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 8'h81 || rsp_op !== 4'd4) begin n_fail++; $display("FAIL fill_first_rsp got v=%b d=%h op=%h exp 1/81/4", rsp_valid, rsp_data, rsp_op); end
        for (int k = 0; k < 10; k++) begin
            step();
            if (rsp_valid !== 1'b1 || rsp_data !== 8'h81 || {alu_a, alu_b, alu_op} !== 12'h184) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL backpressure_stable got %0d unstable cycles exp 0", bad); end
        rsp_ready = 1'b1;
        step();
        n_checks++;
        if (rsp_valid !== 1'b0 || {alu_a, alu_b, alu_op} !== 12'h295 || fifo_count !== 3'd3) begin
            n_fail++; $display("FAIL release_issue got v=%b alu=%h cnt=%0d exp 0/295/3", rsp_valid, {alu_a, alu_b, alu_op}, fifo_count);
        end
        step();
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 8'h92 || rsp_op !== 4'd5) begin n_fail++; $display("FAIL release_rsp got v=%b d=%h op=%h exp 1/92/5", rsp_valid, rsp_data, rsp_op); end
        for (int j = 2; j < 5; j++) begin
            step();
            n_checks++;
            if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL drain_gap_%0d got v=%b exp 0", j, rsp_valid); end
            step();
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== {4'(j + 8), 4'(j + 1)} || rsp_op !== 4'(j + 4)) begin
                n_fail++; $display("FAIL drain_rsp_%0d got v=%b d=%h op=%h exp 1/%h/%h", j, rsp_valid, rsp_data, rsp_op, {4'(j + 8), 4'(j + 1)}, 4'(j + 4));
            end
        end
        step();
        n_checks++;
        if (busy !== 1'b0 || fifo_count !== 3'd0) begin n_fail++; $display("FAIL drain_idle got busy=%b cnt=%0d exp 0/0", busy, fifo_count); end
        rsp_ready = 1'b0;
    endtask

    task automatic test_stream();
        logic [3:0] sa [8];
        logic [3:0] sb [8];
        logic [3:0] so [8];
        int got   = 0;
        int extra = 0;
        int stall = 0;
        for (int i = 0; i < 8; i++) begin
            sa[i] = 4'($urandom_range(0, 15));
            sb[i] = 4'($urandom_range(0, 15));
            so[i] = 4'($urandom_range(0, 15));
        end
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    int t = 0;
                    repeat ($urandom_range(0, 2)) step();
                    cmd_a = sa[i]; cmd_b = sb[i]; cmd_op = so[i]; cmd_chain = 1'b0; cmd_valid = 1'b1;
                    while (!cmd_ready && t < 200) begin step(); t++; end
                    if (t >= 200) stall++;
                    step();
                    cmd_valid = 1'b0;
                end
            end
            begin
                int cyc = 0;
                while (got < 8 && cyc < 600) begin
                    rsp_ready = 1'($urandom_range(0, 1));
                    if (rsp_valid && rsp_ready) begin
                        n_checks++;
                        if (rsp_data !== {sb[got], sa[got]} || rsp_op !== so[got]) begin
                            n_fail++; $display("FAIL stream_rsp_%0d got d=%h op=%h exp %h/%h", got, rsp_data, rsp_op, {sb[got], sa[got]}, so[got]);
                        end
                        got++;
                    end
                    step();
                    cyc++;
                end
            end
        join
        n_checks++;
        if (got != 8 || stall != 0) begin n_fail++; $display("FAIL stream_complete got %0d responses, %0d push stalls exp 8/0", got, stall); end
        rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (rsp_valid) extra++;
            step();
        end
        n_checks++;
        if (extra != 0 || fifo_count !== 3'd0) begin n_fail++; $display("FAIL stream_extra got %0d extra cnt=%0d exp 0/0", extra, fifo_count); end
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cmd_a = 4'(i + 2); cmd_b = 4'(i + 1); cmd_op = 4'(i); cmd_chain = 1'b0; cmd_valid = 1'b1;
            step();
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        n_checks++;
        if (fifo_count !== 3'd2 || rsp_valid !== 1'b0 || alu_a !== 4'd3) begin
            n_fail++; $display("FAIL rstmid_pre got cnt=%0d v=%b a=%h exp 2/0/3", fifo_count, rsp_valid, alu_a);
        end
        rst = 1'b1;
        step();
        n_checks++;
        if (fifo_count !== 3'd0 || rsp_valid !== 1'b0 || {alu_a, alu_b, alu_op} !== 12'h000 || busy !== 1'b0 || cmd_ready !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_post got cnt=%0d v=%b alu=%h busy=%b rdy=%b exp 0/0/000/0/0", fifo_count, rsp_valid, {alu_a, alu_b, alu_op}, busy, cmd_ready);
        end
        rst = 1'b0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            if (rsp_valid || busy) seen++;
        end
        n_checks++;
        if (seen != 0) begin n_fail++; $display("FAIL rstmid_no_rsp got %0d active cycles exp 0", seen); end
        rsp_ready = 1'b0;
    endtask

    task automatic test_chain();
        logic [7:0] res [3];
        logic [7:0] exp_r [3];
        logic [3:0] ca [3] = '{4'd5, 4'd7, 4'd0};
        logic [3:0] cb [3] = '{4'd3, 4'd1, 4'd2};
        logic       cc [3] = '{1'b1, 1'b0, 1'b1};
        int got = 0;
        int cyc = 0;
`ifdef ALU_SEQ_CHAIN_EN
        exp_r = '{8'h30, 8'h17, 8'h27};
`else
        exp_r = '{8'h35, 8'h17, 8'h20};
`endif
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cmd_a = ca[i]; cmd_b = cb[i]; cmd_op = 4'(i + 1); cmd_chain = cc[i]; cmd_valid = 1'b1;
            step();
        end
        cmd_valid = 1'b0; cmd_chain = 1'b0;
        while (got < 3 && cyc < 50) begin
            if (rsp_valid) begin res[got] = rsp_data; got++; end
            step();
            cyc++;
        end
        n_checks++;
        if (got != 3) begin n_fail++; $display("FAIL chain_count got %0d exp 3", got); end
        for (int i = 0; i < 3; i++) begin
            if (i < got) begin
                n_checks++;
                if (res[i] !== exp_r[i]) begin n_fail++; $display("FAIL chain_rsp_%0d got %h exp %h", i, res[i], exp_r[i]); end
            end
        end
        rsp_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout after %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_fill_backpressure();
        test_stream();
        test_reset_mid();
        test_chain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
